// File: rtl/conf_mul_sched_pkg.sv
// Shared types and widths for the apx-first multiplier scheduler.
package conf_mul_sched_pkg;
  localparam int B_OFFSET = 11;
  localparam int PROD_W   = 32;
  localparam int CNT_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_RESP = 3'd2
  } state_e;
endpackage

// File: rtl/conf_mul_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past each winner.
module conf_mul_rr_arb2 (
  input  logic       clk,
  input  logic       rstN,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  // A grant is always a handshake (ready is the grant); the next preference is the loser.
  assign ptr_d = (gnt_o != 2'b00) ? gnt_o[0] : ptr_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/conf_mul_apx_first_sched.sv
// Shares one configurable-accuracy multiplier between row/column passes with an apx-first mode policy.
// Optional statistics counters: define CONF_MUL_SCHED_STATS_EN.
module conf_mul_apx_first_sched
  import conf_mul_sched_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int MUL_LAT            = 2,
  parameter int BLOCK_LEN          = 64,
  parameter int APX_FIRST          = 32
) (
  input  logic                                      clk,
  input  logic                                      rstN,
  input  logic [1:0]                                req_valid,
  output logic [1:0]                                req_ready,
  input  logic [2*DATA_PATH_BITWIDTH-1:0]           req_a,
  input  logic [2*(DATA_PATH_BITWIDTH-B_OFFSET)-1:0] req_b,
  input  logic [1:0]                                req_acc,
  input  logic                                      blk_clr,
  output logic [DATA_PATH_BITWIDTH-1:0]             mul_a,
  output logic [DATA_PATH_BITWIDTH-B_OFFSET-1:0]    mul_b,
  output logic                                      mul_acc_sel,
  output logic [2:0]                                mul_state,
  output logic [CNT_W-1:0]                          mul_count0,
  input  logic [PROD_W-1:0]                         mul_p,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [PROD_W-1:0]                         rsp_p,
  output logic                                      rsp_id,
  output logic                                      rsp_acc,
  output logic                                      blk_done,
  output logic [15:0]                               stat_acc,
  output logic [15:0]                               stat_apx
);
  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int BW = DATA_PATH_BITWIDTH - B_OFFSET;
  localparam logic [3:0]       SETTLE_INIT = 4'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] APX_FIRST_C = CNT_W'(APX_FIRST);

  state_e            state_q, state_d;
  logic [3:0]        settle_q;
  logic [DW-1:0]     a_q;
  logic [BW-1:0]     b_q;
  logic              sel_q, id_q, racc_q, done_q, done_d;
  logic [PROD_W-1:0] p_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt;
  logic              hs, win_id, accept, settled;

  conf_mul_rr_arb2 u_arb (
    .clk   (clk),
    .rstN  (rstN),
    .en_i  (state_q == ST_IDLE),
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  assign hs      = |gnt;
  assign win_id  = gnt[1];
  assign settled = (state_q == ST_EXEC) && (settle_q == 4'd0);
  assign accept  = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs)        state_d = ST_EXEC;
      ST_EXEC: if (settled)   state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = gnt;
    rsp_valid = (state_q == ST_RESP);
    mul_state = state_q;
  end

  // Clear takes priority over the wrap, so a cleared block never reports done.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (blk_clr) cnt_d = '0;
    else if (accept) begin
      if (cnt_q == LAST_C) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 1'b0;
      id_q     <= 1'b0;
      p_q      <= '0;
      racc_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      if (hs) begin
        a_q      <= win_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        b_q      <= win_id ? req_b[2*BW-1:BW] : req_b[BW-1:0];
        sel_q    <= req_acc[win_id] & (cnt_q >= APX_FIRST_C);
        id_q     <= win_id;
        settle_q <= SETTLE_INIT;
      end else if (state_q == ST_EXEC && settle_q != 4'd0) begin
        settle_q <= settle_q - 4'd1;
      end
      if (settled) begin
        p_q    <= mul_p;
        racc_q <= sel_q;
      end
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_acc_sel = sel_q;
  assign mul_count0  = cnt_q;
  assign rsp_p       = p_q;
  assign rsp_id      = id_q;
  assign rsp_acc     = racc_q;
  assign blk_done    = done_q;

`ifdef CONF_MUL_SCHED_STATS_EN
  logic [15:0] sacc_q, sapx_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sacc_q <= '0;
      sapx_q <= '0;
    end else if (accept) begin
      if (racc_q && sacc_q != 16'hFFFF)       sacc_q <= sacc_q + 16'd1;
      else if (!racc_q && sapx_q != 16'hFFFF) sapx_q <= sapx_q + 16'd1;
    end
  end

  assign stat_acc = sacc_q;
  assign stat_apx = sapx_q;
`else
  assign stat_acc = '0;
  assign stat_apx = '0;
`endif
endmodule

// File: tb/tb_conf_mul_apx_first_sched.sv
// Randomized + directed bench for conf_mul_apx_first_sched against a cycle-level reference model.
module tb_conf_mul_apx_first_sched;
  localparam int DW = 24, BW = 13, MUL_LAT = 2, BLOCK_LEN = 64, APX_FIRST = 32;

  logic            clk = 1'b0, rstN = 1'b0;
  logic [1:0]      req_valid = '0, req_ready, req_acc = '0;
  logic [2*DW-1:0] req_a = '0;
  logic [2*BW-1:0] req_b = '0;
  logic            blk_clr = 1'b0, rsp_ready = 1'b0;
  logic [DW-1:0]   mul_a;
  logic [BW-1:0]   mul_b;
  logic            mul_acc_sel, rsp_valid, rsp_id, rsp_acc, blk_done;
  logic [2:0]      mul_state;
  logic [8:0]      mul_count0;
  logic [31:0]     mul_p, rsp_p;
  logic [15:0]     stat_acc, stat_apx;
  logic [36:0]     full_prod;

  int errs = 0, checks = 0;

  conf_mul_apx_first_sched #(.DATA_PATH_BITWIDTH(DW), .MUL_LAT(MUL_LAT),
    .BLOCK_LEN(BLOCK_LEN), .APX_FIRST(APX_FIRST)) dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc), .blk_clr(blk_clr),
    .mul_a(mul_a), .mul_b(mul_b), .mul_acc_sel(mul_acc_sel), .mul_state(mul_state),
    .mul_count0(mul_count0), .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .rsp_acc(rsp_acc), .blk_done(blk_done),
    .stat_acc(stat_acc), .stat_apx(stat_apx));

  // Combinational multiplier stand-in.
  assign full_prod = {13'd0, mul_a} * {24'd0, mul_b};
  assign mul_p     = full_prod[31:0];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt, m_cyc, m_sacc, m_sapx;
  bit          m_busy, m_ptr, m_done, m_id, m_mode;
  logic [DW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic [63:0]   m_prod;

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    if (!rstN) begin
      m_cnt = 0; m_busy = 0; m_ptr = 0; m_done = 0; m_sacc = 0; m_sapx = 0; m_cyc = 0;
    end else begin
      chk("count0", 32'(mul_count0), 32'(m_cnt));
      chk("blk_done", 32'(blk_done), 32'(m_done));
`ifdef CONF_MUL_SCHED_STATS_EN
      chk("stat_acc", 32'(stat_acc), 32'(m_sacc));
      chk("stat_apx", 32'(stat_apx), 32'(m_sapx));
`else
      chk("stat_acc_off", 32'(stat_acc), 32'd0);
      chk("stat_apx_off", 32'(stat_apx), 32'd0);
`endif
      m_done = 0;
      if (!m_busy) begin
        if (req_valid == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
        else                    exp_rdy = req_valid;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_state", 32'(mul_state), 32'd0);
        if (exp_rdy != 2'b00) begin
          m_id   = exp_rdy[1];
          m_a    = m_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
          m_b    = m_id ? req_b[2*BW-1:BW] : req_b[BW-1:0];
          m_mode = req_acc[m_id] && (m_cnt >= APX_FIRST);
          m_prod = 64'(m_a) * 64'(m_b);
          m_ptr  = !m_id;
          m_busy = 1; m_cyc = 0;
        end
      end else begin
        m_cyc++;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (m_cyc <= MUL_LAT) begin
          chk("exec_state", 32'(mul_state), 32'd1);
          chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
          chk("exec_mul_a", 32'(mul_a), 32'(m_a));
          chk("exec_mul_b", 32'(mul_b), 32'(m_b));
          chk("exec_acc_sel", 32'(mul_acc_sel), 32'(m_mode));
        end else begin
          chk("resp_state", 32'(mul_state), 32'd2);
          chk("rsp_valid", 32'(rsp_valid), 32'd1);
          chk("rsp_p", rsp_p, m_prod[31:0]);
          chk("rsp_id", 32'(rsp_id), 32'(m_id));
          chk("rsp_acc", 32'(rsp_acc), 32'(m_mode));
          if (rsp_ready) begin
            m_busy = 0;
            if (m_mode) m_sacc = (m_sacc < 65535) ? m_sacc + 1 : m_sacc;
            else        m_sapx = (m_sapx < 65535) ? m_sapx + 1 : m_sapx;
            if (!blk_clr) begin
              if (m_cnt == BLOCK_LEN - 1) begin m_cnt = 0; m_done = 1; end
              else m_cnt++;
            end
          end
        end
      end
      if (blk_clr) m_cnt = 0;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input int id, input logic [DW-1:0] a, input logic [BW-1:0] b,
                        input bit acc, output int lat, output bit sel, output bit racc,
                        output logic [31:0] p, output bit rid, output bit bd);
    bit got;
    @(posedge clk); #1;
    req_valid = '0; req_valid[id] = 1'b1; req_acc[id] = acc; rsp_ready = 1'b1;
    if (id == 0) begin req_a[DW-1:0] = a; req_b[BW-1:0] = b; end
    else         begin req_a[2*DW-1:DW] = a; req_b[2*BW-1:BW] = b; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req_ready[id]; end
    chk("grant_timeout", 32'(got), 32'd1);
    @(posedge clk); #1; req_valid = '0;
    lat = 0; got = 0; sel = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) sel = mul_acc_sel;
      if (rsp_valid) begin got = 1; lat = i; end
    end
    chk("rsp_timeout", 32'(got), 32'd1);
    racc = rsp_acc; p = rsp_p; rid = rsp_id;
    @(negedge clk); bd = blk_done;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, nacc, g, sacc0, sapx0;
    bit sel, racc, rid, bd, got;
    logic [31:0] p, hold_p;
    logic [1:0] hs;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(mul_state), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_count0", 32'(mul_count0), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    @(posedge clk); #1; rstN = 1'b1;

    // single request 100*3, approximate because count0 < APX_FIRST
    run_op(0, 24'd100, 13'd3, 1'b1, lat, sel, racc, p, rid, bd);
    chk("t1_acc_sel", 32'(sel), 32'd0);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_rsp_p", p, 32'd300);
    chk("t1_rsp_id", 32'(rid), 32'd0);
    chk("t1_rsp_acc", 32'(racc), 32'd0);
    chk("t1_count0", 32'(mul_count0), 32'd1);

    // both valid: pointer was moved to 1 by the previous grant to 0
    @(posedge clk); #1;
    req_valid = 2'b11; req_a = {24'd7, 24'd9}; req_b = {13'd2, 13'd5}; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = 0; g = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin got = 1; g = int'(req_ready[1]); end
      end
      chk("alt_timeout", 32'(got), 32'd1);
      chk("alt_grant", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1; req_valid = '0;
    repeat (MUL_LAT + 4) @(posedge clk);

    // response backpressure
    #1; rsp_ready = 1'b0; req_valid = 2'b01; req_a[DW-1:0] = 24'd11; req_b[BW-1:0] = 13'd13;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req_ready[0]; end
    @(posedge clk); #1; req_valid = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rsp_valid; end
    chk("bp_rsp_timeout", 32'(got), 32'd1);
    hold_p = rsp_p;
    chk("bp_rsp_p", hold_p, 32'd143);
    @(posedge clk); #1; req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_p", rsp_p, hold_p);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      if (i < 9) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);

    // reset while in EXEC
    #1; req_valid = 2'b10; req_a[2*DW-1:DW] = 24'd5; req_b[2*BW-1:BW] = 13'd7;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req_ready[1]; end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #3; rstN = 1'b0; #1;
    chk("mid_rst_state", 32'(mul_state), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_p", rsp_p, 32'd0);
    chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
    chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
    chk("mid_rst_count0", 32'(mul_count0), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_stats", {stat_acc, stat_apx}, 32'd0);
    repeat (2) @(posedge clk); #1; rstN = 1'b1;
    repeat (5) @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_ptr", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = '0;
    repeat (MUL_LAT + 4) @(posedge clk);

    // full block with acc requested on every op
    #1; blk_clr = 1'b1; @(posedge clk); #1; blk_clr = 1'b0;
    @(negedge clk);
    sacc0 = int'(stat_acc); sapx0 = int'(stat_apx);
    ndone = 0; nacc = 0;
    for (int k = 0; k < BLOCK_LEN; k++) begin
      run_op(k % 2, DW'(k + 1), 13'd2, 1'b1, lat, sel, racc, p, rid, bd);
      chk("blk_mode", 32'(racc), (k >= 32) ? 32'd1 : 32'd0);
      nacc += int'(racc);
      if (bd) begin ndone++; chk("blk_done_op", 32'(k), 32'd63); end
    end
    chk("blk_acc_count", 32'(nacc), 32'd32);
    chk("blk_done_count", 32'(ndone), 32'd1);
    chk("blk_count0_wrap", 32'(mul_count0), 32'd0);
`ifdef CONF_MUL_SCHED_STATS_EN
    chk("blk_stat_acc", 32'(int'(stat_acc) - sacc0), 32'd32);
    chk("blk_stat_apx", 32'(int'(stat_apx) - sapx0), 32'd32);
`else
    chk("blk_stat_acc_off", 32'(stat_acc), 32'd0);
    chk("blk_stat_apx_off", 32'(stat_apx), 32'd0);
`endif

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_acc[i]   = ($urandom_range(0, 3) != 0);
          if (i == 0) begin
            req_a[DW-1:0] = DW'($urandom); req_b[BW-1:0] = BW'($urandom);
          end else begin
            req_a[2*DW-1:DW] = DW'($urandom); req_b[2*BW-1:BW] = BW'($urandom);
          end
        end else if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      blk_clr   = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1; req_valid = '0; blk_clr = 1'b0; rsp_ready = 1'b1;
    repeat (MUL_LAT + 5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
